// File: rtl/soc_bus_bridge_pkg.sv
// Shared types and constants for the single-master data-bus bridge.
package soc_bus_bridge_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam logic [DATA_W-1:0] BRIDGE_ERR_RD_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} bridge_state_t;

   // What the bridge remembers about the transfer it is tracking.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wr;
   } req_info_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/soc_bus_bridge_if.sv
// Core-side data bus: the core is the master, the bridge is the slave.
interface soc_bus_bridge_if;
   import soc_bus_bridge_pkg::*;
   logic [ADDR_W-1:0] addr;
   logic [BE_W-1:0]   be;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              ack;
   logic              err;

   modport master (output addr, be, wr_en, wr_data, rd_en,
                   input  rd_data, busy, ack, err);
   modport slave  (input  addr, be, wr_en, wr_data, rd_en,
                   output rd_data, busy, ack, err);
endinterface

// File: rtl/soc_bridge_decoder.sv
// Priority address decoder: peripheral i matches on (addr & mask) == base,
// the lowest matching index wins when windows overlap.
module soc_bridge_decoder
   import soc_bus_bridge_pkg::*;
#(
   parameter int NUM = 3,
   parameter int IW  = idx_w(NUM)
)(
   input  logic [ADDR_W-1:0]          addr,
   input  logic [NUM-1:0][ADDR_W-1:0] base,
   input  logic [NUM-1:0][ADDR_W-1:0] mask,
   output logic [NUM-1:0]             hit_oh,
   output logic [IW-1:0]              idx,
   output logic                       miss
);
   logic [NUM-1:0] hit;

   for (genvar g = 0; g < NUM; g++) begin : g_hit
      assign hit[g] = (addr & mask[g]) == base[g];
   end

   // Scan from the top so the lowest hit is the last one written.
   always_comb begin
      hit_oh = '0;
      idx    = '0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
            idx       = IW'(i);
         end
      end
   end

   assign miss = ~|hit;
endmodule

// File: rtl/soc_bus_bridge.sv
// Data-bus to N-peripheral bridge: decodes, tracks one outstanding transfer,
// and turns unmapped or timed-out accesses into error acks.
module soc_bus_bridge
   import soc_bus_bridge_pkg::*;
#(
   parameter int                p_num_periphs = 3,
   parameter int                p_timeout     = 255,
   parameter logic [DATA_W-1:0] p_err_rd_data = BRIDGE_ERR_RD_DATA
)(
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   soc_bus_bridge_if.slave                       dbus,
   input  logic [p_num_periphs-1:0][ADDR_W-1:0]  i_base,
   input  logic [p_num_periphs-1:0][ADDR_W-1:0]  i_mask,
   output logic [p_num_periphs-1:0][ADDR_W-1:0]  o_addr,
   output logic [p_num_periphs-1:0][BE_W-1:0]    o_be,
   output logic [p_num_periphs-1:0]              o_wr_en,
   output logic [p_num_periphs-1:0][DATA_W-1:0]  o_wr_data,
   output logic [p_num_periphs-1:0]              o_rd_en,
   input  logic [p_num_periphs-1:0][DATA_W-1:0]  i_rd_data,
   input  logic [p_num_periphs-1:0]              i_busy,
   input  logic [p_num_periphs-1:0]              i_ack,
   output logic [15:0]                           o_err_count,
   output logic [ADDR_W-1:0]                     o_err_addr
);
   localparam int IW = idx_w(p_num_periphs);
   localparam int CW = $clog2(p_timeout);

   bridge_state_t     state_q, state_d;
   logic [IW-1:0]     sel_q, sel_d;
   req_info_t         req_q, req_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   logic [p_num_periphs-1:0] hit_oh;
   logic [IW-1:0]            win;
   logic                     miss, req, ack_sel;
   logic                     bus_ack, bus_err, bus_busy;
   logic [DATA_W-1:0]        bus_rd_data;

   soc_bridge_decoder #(.NUM(p_num_periphs), .IW(IW)) u_dec (
      .addr   (dbus.addr),
      .base   (i_base),
      .mask   (i_mask),
      .hit_oh (hit_oh),
      .idx    (win),
      .miss   (miss)
   );

   for (genvar g = 0; g < p_num_periphs; g++) begin : g_port
      assign o_addr[g]    = dbus.addr & ~i_mask[g];
      assign o_be[g]      = dbus.be;
      assign o_wr_data[g] = dbus.wr_data;
   end

   assign req     = dbus.wr_en | dbus.rd_en;
   assign ack_sel = i_ack[sel_q];

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      req_d       = req_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      err_addr_d  = err_addr_q;
      o_wr_en     = '0;
      o_rd_en     = '0;
      bus_ack     = 1'b0;
      bus_err     = 1'b0;
      bus_busy    = 1'b0;
      bus_rd_data = '0;
      unique case (state_q)
         ST_IDLE: if (req) begin
            req_d = '{addr: dbus.addr, wr: dbus.wr_en};
            cnt_d = '0;
            if (miss) begin
               state_d    = ST_ERR;
               err_addr_d = dbus.addr;
            end else begin
               state_d = ST_WAIT;
               sel_d   = win;
               if (dbus.wr_en) o_wr_en = hit_oh;
               else            o_rd_en = hit_oh;
            end
         end
         ST_WAIT: begin
            if (ack_sel) begin
               bus_ack     = 1'b1;
               bus_rd_data = req_q.wr ? '0 : i_rd_data[sel_q];
               state_d     = ST_IDLE;
            end else begin
               // Peripheral busy is mirrored, but WAIT already holds the core off.
               bus_busy = i_busy[sel_q] | 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CW'(p_timeout - 1)) begin
                  state_d    = ST_ERR;
                  err_addr_d = req_q.addr;
               end
            end
         end
         ST_ERR: begin
            bus_ack     = 1'b1;
            bus_err     = 1'b1;
            bus_rd_data = req_q.wr ? '0 : p_err_rd_data;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         req_q      <= '0;
         cnt_q      <= '0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign dbus.ack     = bus_ack;
   assign dbus.err     = bus_err;
   assign dbus.busy    = bus_busy;
   assign dbus.rd_data = bus_rd_data;
   assign o_err_count  = err_cnt_q;
   assign o_err_addr   = err_addr_q;
endmodule

// File: tb/tb_soc_bus_bridge.sv
// Bench for soc_bus_bridge: fixed vector table, corner-case sequences and
// random transfers checked against a transaction-level model.
module tb_soc_bus_bridge;
   import soc_bus_bridge_pkg::*;
   localparam int N   = 3;
   localparam int TMO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   soc_bus_bridge_if dbus();
   logic [N-1:0][31:0] base, mask, o_addr, o_wr_data, rd_data;
   logic [N-1:0][3:0]  o_be;
   logic [N-1:0]       o_wr_en, o_rd_en, busy_p, ack_p;
   logic [15:0]        err_count;
   logic [31:0]        err_addr;

   soc_bus_bridge #(.p_num_periphs(N), .p_timeout(TMO), .p_err_rd_data(32'hDEADBEEF)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .dbus(dbus.slave),
      .i_base(base), .i_mask(mask), .o_addr(o_addr), .o_be(o_be),
      .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en),
      .i_rd_data(rd_data), .i_busy(busy_p), .i_ack(ack_p),
      .o_err_count(err_count), .o_err_addr(err_addr)
   );

   typedef struct {
      logic [31:0] addr;
      bit          wr;
      bit          rd;
      int          port;
      int          lat;       // WAIT cycle in which the peripheral acks, 0 = never
      logic [31:0] rdat;
      logic [N-1:0] exp_wr;
      logic [N-1:0] exp_rd;
      int          exp_cyc;   // cycles from request to dbus_ack
      bit          exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        tbl[8];
   int          n_chk = 0;
   int          n_err = 0;
   int          m_err_cnt = 0;
   logic [31:0] m_err_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic string tag(input int id, input string s);
      return $sformatf("v%0d %s", id, s);
   endfunction

   // Reference: first window (lowest index) that contains the address.
   function automatic int ref_winner(input logic [31:0] a);
      for (int i = 0; i < N; i++) if ((a & mask[i]) == base[i]) return i;
      return -1;
   endfunction

   function automatic vec_t make_vec(input logic [31:0] a, input bit wr, input bit rd,
                                     input int lat, input logic [31:0] rdat);
      vec_t v;
      int   w;
      w = ref_winner(a);
      v.addr = a; v.wr = wr; v.rd = rd; v.lat = lat; v.rdat = rdat;
      v.port = (w < 0) ? 0 : w;
      v.exp_wr = '0; v.exp_rd = '0;
      if (w < 0) begin
         v.exp_cyc = 1; v.exp_err = 1'b1;
      end else begin
         if (wr) v.exp_wr[w] = 1'b1; else v.exp_rd[w] = 1'b1;
         if (lat >= 1 && lat <= TMO) begin v.exp_cyc = lat;     v.exp_err = 1'b0; end
         else                        begin v.exp_cyc = TMO + 1; v.exp_err = 1'b1; end
      end
      v.exp_data = wr ? 32'h0 : (v.exp_err ? 32'hDEADBEEF : rdat);
      return v;
   endfunction

   task automatic idle();
      @(negedge clk);
      dbus.wr_en = 1'b0; dbus.rd_en = 1'b0; ack_p = '0;
   endtask

   // Present one request, act as the peripheral, and check the whole transfer.
   task automatic run_vec(input int id, input vec_t v, input bit noise);
      logic [N-1:0] extra;
      logic [31:0]  wd, got_data;
      logic [3:0]   be;
      int           cyc;
      bit           got_err, busy_bad;
      @(negedge clk);
      wd = $urandom; be = 4'($urandom);
      dbus.addr = v.addr; dbus.wr_en = v.wr; dbus.rd_en = v.rd;
      dbus.wr_data = wd; dbus.be = be;
      ack_p = '0; busy_p = '0;
      for (int k = 0; k < N; k++) rd_data[k] = $urandom;
      rd_data[v.port] = v.rdat;
      #1;
      chk(tag(id, "wr_strobe"), 32'(o_wr_en), 32'(v.exp_wr));
      chk(tag(id, "rd_strobe"), 32'(o_rd_en), 32'(v.exp_rd));
      chk(tag(id, "req_busy"), 32'(dbus.busy), 32'd0);
      chk(tag(id, "req_ack"), 32'(dbus.ack), 32'd0);
      chk(tag(id, "err_count"), 32'(err_count), 32'(m_err_cnt));
      chk(tag(id, "err_addr"), err_addr, m_err_addr);
      for (int k = 0; k < N; k++) chk(tag(id, "o_addr"), o_addr[k], v.addr & ~mask[k]);
      chk(tag(id, "o_be"), 32'(o_be[N-1]), 32'(be));
      chk(tag(id, "o_wr_data"), o_wr_data[N-1], wd);
      cyc = -1; extra = '0; busy_bad = 1'b0; got_err = 1'b0; got_data = '0;
      for (int c = 1; c <= 3 * TMO && cyc < 0; c++) begin
         @(negedge clk);
         ack_p  = noise ? (N'($urandom) & ~(N'(1) << v.port)) : '0;
         busy_p = N'($urandom);
         if (c == v.lat) ack_p[v.port] = 1'b1;
         #1;
         extra = extra | o_wr_en | o_rd_en;
         if (dbus.ack) begin
            cyc = c; got_err = dbus.err; got_data = dbus.rd_data;
            if (dbus.busy) busy_bad = 1'b1;
         end else if (!dbus.busy) busy_bad = 1'b1;
      end
      chk(tag(id, "ack_cycle"), 32'(cyc), 32'(v.exp_cyc));
      chk(tag(id, "ack_err"), 32'(got_err), 32'(v.exp_err));
      chk(tag(id, "rd_data"), got_data, v.exp_data);
      chk(tag(id, "extra_strobes"), 32'(extra), 32'd0);
      chk(tag(id, "busy_profile"), 32'(busy_bad), 32'd0);
      if (got_err) chk(tag(id, "err_addr_at_ack"), err_addr, v.addr);
      if (v.exp_err) begin
         if (m_err_cnt < 16'hFFFF) m_err_cnt++;
         m_err_addr = v.addr;
      end
   endtask

   initial begin
      logic [31:0] a;
      int          r, op, lat;
      dbus.addr = '0; dbus.be = '0; dbus.wr_en = 1'b0; dbus.wr_data = '0; dbus.rd_en = 1'b0;
      ack_p = '0; busy_p = '0; rd_data = '0;
      base = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
      mask = {32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

      repeat (2) @(negedge clk);
      #1;
      chk("reset ack", 32'(dbus.ack), 32'd0);
      chk("reset err", 32'(dbus.err), 32'd0);
      chk("reset busy", 32'(dbus.busy), 32'd0);
      chk("reset rd_data", dbus.rd_data, 32'd0);
      chk("reset strobes", 32'({o_wr_en, o_rd_en}), 32'd0);
      chk("reset err_count", 32'(err_count), 32'd0);
      chk("reset err_addr", err_addr, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      //            addr          wr rd port lat rdat          exp_wr  exp_rd  cyc err data
      tbl[0] = '{32'h2000_0100, 0, 1, 1, 3, 32'h0000_1234, 3'b000, 3'b010, 3,  0, 32'h0000_1234};
      tbl[1] = '{32'h7000_0010, 1, 0, 0, 1, 32'h1111_1111, 3'b000, 3'b000, 1,  1, 32'h0};
      tbl[2] = '{32'h1000_0004, 0, 1, 0, 0, 32'h2222_2222, 3'b000, 3'b001, 9,  1, 32'hDEADBEEF};
      tbl[3] = '{32'h3000_0ABC, 1, 0, 2, 1, 32'h0000_0055, 3'b100, 3'b000, 1,  0, 32'h0};
      tbl[4] = '{32'h1000_0008, 1, 1, 0, 8, 32'h3333_3333, 3'b001, 3'b000, 8,  0, 32'h0};
      tbl[5] = '{32'h3001_0000, 0, 1, 0, 0, 32'h4444_4444, 3'b000, 3'b000, 1,  1, 32'hDEADBEEF};
      tbl[6] = '{32'h3000_FFFC, 0, 1, 2, 2, 32'hCAFE_F00D, 3'b000, 3'b100, 2,  0, 32'hCAFE_F00D};
      tbl[7] = '{32'h1000_0000, 0, 1, 0, 9, 32'h5555_5555, 3'b000, 3'b001, 9,  1, 32'hDEADBEEF};
      for (int i = 0; i < 8; i++) begin
         run_vec(i, tbl[i], 1'b0);
         idle();
      end

      // Stray ack from the timed-out peripheral after the error ack.
      run_vec(20, tbl[2], 1'b1);
      idle(); ack_p[0] = 1'b1; #1;
      chk("stray_ack ack", 32'(dbus.ack), 32'd0);
      chk("stray_ack busy", 32'(dbus.busy), 32'd0);

      // Overlapping windows: lowest index wins.
      base[2] = 32'h1000_0000; mask[2] = 32'hF000_0000;
      run_vec(30, '{32'h1000_0040, 1, 0, 0, 2, 32'h0, 3'b001, 3'b000, 2, 0, 32'h0}, 1'b1);
      base[2] = 32'h2000_0000;
      run_vec(31, '{32'h2000_0040, 0, 1, 1, 1, 32'h0000_0777, 3'b000, 3'b010, 1, 0, 32'h0000_0777}, 1'b0);
      base[2] = 32'h3000_0000; mask[2] = 32'hFFFF_0000;
      idle();

      // Back-to-back immediate acks: each request in the IDLE cycle after the previous ack.
      run_vec(40, '{32'h1000_0100, 0, 1, 0, 1, 32'hAAAA_0000, 3'b000, 3'b001, 1, 0, 32'hAAAA_0000}, 1'b0);
      run_vec(41, '{32'h2000_0200, 0, 1, 1, 1, 32'hBBBB_0000, 3'b000, 3'b010, 1, 0, 32'hBBBB_0000}, 1'b0);
      idle();

      // Reset while waiting for the peripheral.
      @(negedge clk);
      dbus.addr = 32'h1000_0010; dbus.rd_en = 1'b1; dbus.wr_en = 1'b0; ack_p = '0; #1;
      chk("rstmid req_strobe", 32'(o_rd_en), 32'b001);
      @(negedge clk); #1;
      chk("rstmid wait_busy", 32'(dbus.busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0; dbus.rd_en = 1'b0; dbus.addr = '0; #1;
      chk("rstmid busy", 32'(dbus.busy), 32'd0);
      chk("rstmid ack", 32'(dbus.ack), 32'd0);
      chk("rstmid strobes", 32'({o_wr_en, o_rd_en}), 32'd0);
      chk("rstmid o_addr", o_addr[0], 32'd0);
      @(negedge clk);
      rst_n = 1'b1; ack_p[0] = 1'b1; #1;
      chk("rstmid late_ack", 32'(dbus.ack), 32'd0);
      @(negedge clk); ack_p = '0; #1;
      chk("rstmid ack_after", 32'(dbus.ack), 32'd0);
      // Error record is cleared by reset.
      m_err_cnt = 0; m_err_addr = '0;
      chk("rstmid err_count", 32'(err_count), 32'd0);

      // Random transfers against the model.
      for (int t = 0; t < 200; t++) begin
         r = $urandom_range(0, 3);
         case (r)
            0:       a = {4'h1, 28'($urandom)};
            1:       a = {4'h2, 28'($urandom)};
            2:       a = {16'h3000, 16'($urandom)};
            default: a = $urandom;
         endcase
         op  = $urandom_range(1, 3);
         lat = $urandom_range(0, TMO + 2);
         run_vec(1000 + t, make_vec(a, op[0], op[1], lat, $urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
